// File: rtl/pipeline_arb_pkg.sv
// Shared definitions for the IF/MEM single-port memory arbiter:
// FSM state encodings, grant owner constants and default bus widths.
package pipeline_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Loadable up-counter with clear, enable and a terminal-count flag.
// The arbiter uses it as the watchdog for unacknowledged memory accesses.
module arb_timeout_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    // Counter register: clear has priority over load, load over count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            cnt_r <= cnt_r + W'(1);
        end
    end

    assign tc = (cnt_r == term_val);

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Arbiter sharing one single-port memory between the IF and MEM pipeline
// stages. MEM wins ties, limited to MEM_BURST consecutive grants while a
// fetch waits. A watchdog aborts accesses the memory never acknowledges.
// Optional wait-cycle performance counters: define MEM_ARB_PERF_CNT_EN.
module pipeline_mem_arbiter
    import pipeline_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MEM_BURST      = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_err,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [31:0]       if_wait_cnt,
    output logic [31:0]       mem_wait_cnt
);

    localparam int BURST_W = (MEM_BURST < 1) ? 1 : $clog2(MEM_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MEM_BURST);
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_TERM = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_r, state_nx_s;
    grant_t            owner_r;
    logic [BURST_W-1:0] burst_r;
    logic              grant_if_s, grant_mem_s, grant_s;
    logic              done_ok_s, done_to_s, done_s, busy_s, to_tc_s;
    logic [DATA_W-1:0] rdata_s;

    logic              ram_req_r, ram_we_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_wdata_r;
    logic [DATA_W-1:0] if_rdata_r, mem_rdata_r;
    logic              if_ready_r, mem_ready_r, if_err_r, mem_err_r;

    assign busy_s  = (state_r == BUSY_IF) || (state_r == BUSY_MEM);
    assign grant_s = grant_if_s | grant_mem_s;
    assign done_s  = done_ok_s | done_to_s;

    // Watchdog: restarts on every grant, counts cycles spent waiting for ack.
    arb_timeout_ctr #(.W(TO_W)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant_s),
        .load     (1'b0),
        .load_val ({TO_W{1'b0}}),
        .en       (busy_s),
        .term_val (TO_TERM),
        .tc       (to_tc_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: grant selection, completion and watchdog abort.
    always_comb begin
        state_nx_s  = state_r;
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
        done_ok_s   = 1'b0;
        done_to_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_req && !(if_req && (burst_r == BURST_MAX))) begin
                    grant_mem_s = 1'b1;
                    state_nx_s  = BUSY_MEM;
                end else if (if_req) begin
                    grant_if_s = 1'b1;
                    state_nx_s = BUSY_IF;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                // An ack in the watchdog's terminal cycle still counts as success.
                if (ram_ack) begin
                    done_ok_s  = 1'b1;
                    state_nx_s = RESP;
                end else if (to_tc_s) begin
                    done_to_s  = 1'b1;
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = state_r;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Data returned to the owner: stores and aborted accesses return zero.
    always_comb begin
        if (done_ok_s && !ram_we_r) begin
            rdata_s = ram_rdata;
        end else begin
            rdata_s = {DATA_W{1'b0}};
        end
    end

    // Registered memory port, burst counter and per-requester responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_req_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            owner_r     <= GRANT_IF;
            burst_r     <= {BURST_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            mem_rdata_r <= {DATA_W{1'b0}};
            if_ready_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            if_err_r    <= 1'b0;
            mem_err_r   <= 1'b0;
        end else begin
            if_ready_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            if (grant_mem_s) begin
                ram_req_r   <= 1'b1;
                ram_we_r    <= mem_we;
                ram_addr_r  <= mem_addr;
                ram_wdata_r <= mem_wdata;
                owner_r     <= GRANT_MEM;
                if (if_req) begin
                    if (burst_r != BURST_MAX) begin
                        burst_r <= burst_r + BURST_W'(1);
                    end
                end else begin
                    burst_r <= {BURST_W{1'b0}};
                end
            end else if (grant_if_s) begin
                ram_req_r   <= 1'b1;
                ram_we_r    <= 1'b0;
                ram_addr_r  <= if_addr;
                ram_wdata_r <= {DATA_W{1'b0}};
                owner_r     <= GRANT_IF;
                burst_r     <= {BURST_W{1'b0}};
            end else if (done_s) begin
                ram_req_r <= 1'b0;
                if (owner_r == GRANT_MEM) begin
                    mem_ready_r <= 1'b1;
                    mem_rdata_r <= rdata_s;
                    mem_err_r   <= done_to_s;
                end else begin
                    if_ready_r <= 1'b1;
                    if_rdata_r <= rdata_s;
                    if_err_r   <= done_to_s;
                end
            end
        end
    end

    assign ram_req   = ram_req_r;
    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign if_ready  = if_ready_r;
    assign if_err    = if_err_r;
    assign mem_rdata = mem_rdata_r;
    assign mem_ready = mem_ready_r;
    assign mem_err   = mem_err_r;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] if_wait_r, mem_wait_r;

    // Stall-cycle counters: a stage waits while its req is high and ready low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_wait_r  <= 32'd0;
            mem_wait_r <= 32'd0;
        end else begin
            if (if_req && !if_ready_r) begin
                if_wait_r <= if_wait_r + 32'd1;
            end
            if (mem_req && !mem_ready_r) begin
                mem_wait_r <= mem_wait_r + 32'd1;
            end
        end
    end

    assign if_wait_cnt  = if_wait_r;
    assign mem_wait_cnt = mem_wait_r;
`else
    assign if_wait_cnt  = 32'd0;
    assign mem_wait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Self-checking bench for pipeline_mem_arbiter: directed and randomized
// accesses against a transaction-level reference model and memory responder.
module tb_pipeline_mem_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ready, if_err;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_ready, mem_err;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'd0;
    logic        ram_ack = 1'b0;
    logic [31:0] if_wait_cnt, mem_wait_cnt;

    int checks = 0;
    int failures = 0;

    int ack_lat = 1;   // BUSY cycle in which ack is asserted; 0 = never
    int busy_cnt = 0;
    logic [31:0] ram_store [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    pipeline_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_BURST(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_err(if_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_err(mem_err),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .if_wait_cnt(if_wait_cnt), .mem_wait_cnt(mem_wait_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Memory responder: single-cycle ack in the ack_lat-th cycle of ram_req.
    always @(negedge clk) begin
        if (ram_req === 1'b1) begin
            busy_cnt = busy_cnt + 1;
            if (ack_lat != 0 && busy_cnt == ack_lat) begin
                ram_ack = 1'b1;
                ram_rdata = ram_store.exists(ram_addr) ? ram_store[ram_addr] : init_word(ram_addr);
                if (ram_we) ram_store[ram_addr] = ram_wdata;
            end else begin
                ram_ack = 1'b0;
                ram_rdata = $urandom;
            end
        end else begin
            busy_cnt = 0;
            ram_ack = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One access from a single requester; caller is positioned at a negedge.
    task automatic access(input bit is_mem, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input string tag);
        int n, busy, exp_wait;
        bit seen, exp_err, exp_we;
        logic [31:0] exp_rdata, wait_before, wait_after, exp_delta;
        exp_err  = (lat == 0);
        exp_we   = is_mem && we;
        exp_wait = exp_err ? TO + 1 : lat + 1;
        if (exp_err || exp_we) exp_rdata = 32'd0;
        else exp_rdata = ref_rd(addr);
        if (exp_we && !exp_err) ref_mem[addr] = wdata;
        ack_lat = lat;
        wait_before = is_mem ? mem_wait_cnt : if_wait_cnt;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0; busy = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (ram_req === 1'b1) begin
                busy++;
                check({tag, "_ram_addr"}, ram_addr, addr);
                check({tag, "_ram_we"}, ram_we, exp_we);
                if (exp_we) check({tag, "_ram_wdata"}, ram_wdata, wdata);
            end
            check({tag, "_other_ready"}, is_mem ? if_ready : mem_ready, 1'b0);
            if ((is_mem ? mem_ready : if_ready) === 1'b1) seen = 1'b1;
        end
        check({tag, "_ready_seen"}, seen, 1'b1);
        check({tag, "_latency"}, n, exp_wait);
        check({tag, "_busy_cycles"}, busy, exp_wait - 1);
        check({tag, "_rdata"}, is_mem ? mem_rdata : if_rdata, exp_rdata);
        check({tag, "_err"}, is_mem ? mem_err : if_err, exp_err);
        if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
        @(negedge clk);
        check({tag, "_ready_pulse"}, is_mem ? mem_ready : if_ready, 1'b0);
        check({tag, "_ram_req_idle"}, ram_req, 1'b0);
        wait_after = is_mem ? mem_wait_cnt : if_wait_cnt;
`ifdef MEM_ARB_PERF_CNT_EN
        exp_delta = 32'(exp_wait);
`else
        exp_delta = 32'd0;
`endif
        check({tag, "_wait_cnt"}, wait_after - wait_before, exp_delta);
    endtask

    initial begin
        int order_q[$];
        int exp_order[6];
        int grants, n;
        bit prev_req;

        // Reset state
        ram_store[32'h40] = 32'h1234_ABCD;
        ref_mem[32'h40]   = 32'h1234_ABCD;
        @(negedge clk);
        @(negedge clk);
        check("rst_ram_req", ram_req, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_ready", {if_ready, mem_ready, if_err, mem_err}, 4'd0);
        check("rst_rdata", {if_rdata, mem_rdata}, 64'd0);
        check("rst_wait_cnt", {if_wait_cnt, mem_wait_cnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed accesses
        access(1'b1, 1'b0, 32'h40, 32'd0, 2, "load");
        access(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 2, "store");
        access(1'b1, 1'b0, 32'h80, 32'd0, 1, "store_readback");
        access(1'b0, 1'b0, 32'h10, 32'd0, 1, "fetch");

        // Contention: both held, MEM gets at most two grants before IF
        exp_order = '{1, 1, 0, 1, 1, 0};
        ack_lat = 1;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
        grants = 0; n = 0; prev_req = 1'b0;
        while (order_q.size() < 6 && n < 100) begin
            @(negedge clk);
            n++;
            if (ram_req === 1'b1 && !prev_req) grants++;
            prev_req = (ram_req === 1'b1);
            check("cont_one_ready", if_ready & mem_ready, 1'b0);
            if (mem_ready === 1'b1) begin
                order_q.push_back(1);
                check("cont_mem_rdata", mem_rdata, ref_rd(32'h200));
            end
            if (if_ready === 1'b1) begin
                order_q.push_back(0);
                check("cont_if_rdata", if_rdata, ref_rd(32'h100));
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        check("cont_count", order_q.size(), 6);
        check("cont_grants", grants, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < order_q.size()) check("cont_order", order_q[i], exp_order[i]);
        end
        @(negedge clk);
        @(negedge clk);
        check("cont_no_extra", ram_req, 1'b0);

        // Watchdog abort, then a successful fetch clears the error
        access(1'b0, 1'b0, 32'h0, 32'd0, 0, "timeout");
        access(1'b0, 1'b0, 32'h4, 32'd0, 1, "after_timeout");

        // Load with ack three cycles after the request is seen by memory
        access(1'b1, 1'b0, 32'h44, 32'd0, 4, "perf_load");

        // Reset in the middle of a MEM access
        ack_lat = 0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
        repeat (3) @(negedge clk);
        check("midrst_busy", ram_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst_ram_req", ram_req, 1'b0);
        check("midrst_clear", {mem_ready, mem_err, mem_rdata}, 34'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_lat = 1;
        n = 0;
        while (mem_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_latency", n, 2);
        check("midrst_rdata", mem_rdata, ref_rd(32'h300));
        mem_req = 1'b0;
        @(negedge clk);

        // Randomized single-requester traffic
        for (int k = 0; k < 24; k++) begin
            bit r_mem, r_we;
            logic [31:0] r_addr, r_wdata;
            int r_lat;
            r_mem   = 1'($urandom_range(0, 1));
            r_we    = r_mem ? 1'($urandom_range(0, 1)) : 1'b0;
            r_addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
            r_wdata = $urandom;
            r_lat   = (k % 8 == 7) ? 0 : int'($urandom_range(1, 4));
            access(r_mem, r_we, r_addr, r_wdata, r_lat, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
